// File: rtl/id_buffer_pkg.sv
// Shared definitions for the decode-entry buffer: immediate format codes
// (also consumed by the sign-extender) and the RV32I major opcodes.
package id_buffer_pkg;

  typedef enum logic [2:0] {
    IMM_NO = 3'd0,
    IMM_RT = 3'd1,
    IMM_IT = 3'd2,
    IMM_ST = 3'd3,
    IMM_BT = 3'd4,
    IMM_UT = 3'd5,
    IMM_JT = 3'd6
  } imm_type_e;

  localparam logic [6:0] OPC_OP       = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
  localparam logic [6:0] OPC_LOAD     = 7'b0000011;
  localparam logic [6:0] OPC_JALR     = 7'b1100111;
  localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;
  localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;
  localparam logic [6:0] OPC_STORE    = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
  localparam logic [6:0] OPC_LUI      = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
  localparam logic [6:0] OPC_JAL      = 7'b1101111;

endpackage

// File: rtl/imm_type_decode.sv
// Combinational opcode classifier used on the push path: maps an instruction
// word to its immediate format code and an illegal-opcode flag.
module imm_type_decode
  import id_buffer_pkg::*;
(
  input  logic [31:0] instr_i,
  output imm_type_e   imm_type_o,
  output logic        illegal_o
);

  logic illegal_opc_s;
  logic unused_instr_s;

  assign unused_instr_s = ^instr_i[31:7];

  always_comb begin
    imm_type_o    = IMM_NO;
    illegal_opc_s = 1'b0;
    case (instr_i[6:0])
      OPC_OP:                                      imm_type_o = IMM_RT;
      OPC_OP_IMM, OPC_LOAD, OPC_JALR,
      OPC_SYSTEM, OPC_MISC_MEM:                    imm_type_o = IMM_IT;
      OPC_STORE:                                   imm_type_o = IMM_ST;
      OPC_BRANCH:                                  imm_type_o = IMM_BT;
      OPC_LUI, OPC_AUIPC:                          imm_type_o = IMM_UT;
      OPC_JAL:                                     imm_type_o = IMM_JT;
      default: begin
        imm_type_o    = IMM_NO;
        illegal_opc_s = 1'b1;
      end
    endcase
  end

  // Compressed/non-32-bit encodings are illegal whatever the opcode field says.
  assign illegal_o = illegal_opc_s | (instr_i[1:0] != 2'b11);

endmodule

// File: rtl/id_buffer.sv
// Decode-entry buffer: 2-entry skid FIFO between fetch and decode with
// registered ready, push-time immediate classification and flush support.
module id_buffer
  import id_buffer_pkg::*;
#(
  parameter int          PC_WIDTH  = 32,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic                i_valid,
  output logic                o_ready,
  input  logic [31:0]         i_instr,
  input  logic [PC_WIDTH-1:0] i_pc,
  input  logic                i_flush,
  output logic                o_valid,
  input  logic                i_ready,
  output logic [31:0]         o_instr,
  output logic [PC_WIDTH-1:0] o_pc,
  output logic [2:0]          o_imm_type,
  output logic [24:0]         o_imm_data,
  output logic                o_illegal
);

  logic [31:0]         instr_q   [2];
  logic [PC_WIDTH-1:0] pc_q      [2];
  imm_type_e           type_q    [2];
  logic                illegal_q [2];

  logic [1:0] count_q, count_d;
  logic       wr_ptr_q, wr_ptr_d;
  logic       rd_ptr_q, rd_ptr_d;
  logic       ready_q, ready_d;

  imm_type_e  dec_type_s;
  logic       dec_illegal_s;
  logic       push_s;
  logic       pop_s;

  imm_type_decode u_imm_type_decode (
    .instr_i    (i_instr),
    .imm_type_o (dec_type_s),
    .illegal_o  (dec_illegal_s)
  );

  // Flush wins over a same-cycle push so a redirected fetch never lands.
  assign push_s = i_valid && ready_q && !i_flush;
  assign pop_s  = o_valid && i_ready;

  always_comb begin
    count_d  = count_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (i_flush) begin
      count_d  = 2'd0;
      wr_ptr_d = 1'b0;
      rd_ptr_d = 1'b0;
    end else begin
      wr_ptr_d = wr_ptr_q ^ push_s;
      rd_ptr_d = rd_ptr_q ^ pop_s;
      case ({push_s, pop_s})
        2'b10:   count_d = count_q + 2'd1;
        2'b01:   count_d = count_q - 2'd1;
        default: count_d = count_q;
      endcase
    end
    ready_d = (count_d < 2'd2);
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      count_q  <= 2'd0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      ready_q  <= 1'b1;
    end else begin
      count_q  <= count_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      ready_q  <= ready_d;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int i = 0; i < 2; i++) begin
        instr_q[i]   <= NOP_INSTR;
        pc_q[i]      <= '0;
        type_q[i]    <= IMM_NO;
        illegal_q[i] <= 1'b0;
      end
    end else if (push_s) begin
      instr_q[wr_ptr_q]   <= i_instr;
      pc_q[wr_ptr_q]      <= i_pc;
      type_q[wr_ptr_q]    <= dec_type_s;
      illegal_q[wr_ptr_q] <= dec_illegal_s;
    end
  end

  assign o_ready    = ready_q;
  assign o_valid    = (count_q != 2'd0);
  assign o_instr    = o_valid ? instr_q[rd_ptr_q] : NOP_INSTR;
  assign o_pc       = o_valid ? pc_q[rd_ptr_q] : '0;
  assign o_imm_type = o_valid ? type_q[rd_ptr_q] : IMM_NO;
  assign o_illegal  = o_valid ? illegal_q[rd_ptr_q] : 1'b0;
  assign o_imm_data = o_instr[31:7];

endmodule

// File: doc/id_buffer.md
Name: id_buffer

Overview:
- Decode-entry buffer between instruction fetch and the decode stage.
- Accepts fetched instructions over a valid/ready handshake and holds them in a 2-entry skid FIFO.
- Classifies each instruction's immediate format at push time.
- Presents the head entry's type code and instruction bits [31:7] directly to the immediate sign-extender's i_en / i_data inputs, along with the PC and an illegal flag for decode.
- Absorbs decode stalls and branch flushes without combinational ready paths back to fetch.

Parameters:
- PC_WIDTH, 32, width of the program counter carried with each instruction.
- NOP_INSTR, 32'h0000_0013, instruction word presented when the buffer is empty (addi x0,x0,0).

Ports:
- i_clk  input  1  clock, rising edge.
- i_rst  input  1  synchronous, active-high reset.
- i_valid  input  1  fetch presents an instruction.
- o_ready  output  1  buffer can accept this cycle; registered.
- i_instr  input  32  fetched instruction word.
- i_pc  input  PC_WIDTH  PC of i_instr.
- i_flush  input  1  discard all buffered entries (branch/jump redirect).
- o_valid  output  1  head entry valid.
- i_ready  input  1  decode consumes the head this cycle.
- o_instr  output  32  head instruction word.
- o_pc  output  PC_WIDTH  head PC.
- o_imm_type  output  3  immediate format code, feeds the sign-extender i_en.
- o_imm_data  output  25  o_instr[31:7], feeds the sign-extender i_data.
- o_illegal  output  1  head opcode not recognised.

Behaviour:
- Clocking and reset: single clock i_clk. Reset is synchronous and active-high on i_rst.
- Reset values: count=0, o_valid=0, o_ready=1, o_instr=NOP_INSTR, o_pc=0, o_imm_type=NO, o_illegal=0.
- Storage: 2 entries, each holding {instr, pc, imm_type, illegal}.
  - Read and write pointers are 1 bit each and wrap modulo 2.
  - count ranges 0..2.
- Push: i_valid && o_ready. Entry is written at the rising edge.
- Pop: o_valid && i_ready.
- Latency: an instruction pushed at edge N is visible on o_* after edge N (cycle N+1). No same-cycle bypass.
- Outputs:
  - o_valid = (count != 0).
  - o_* reflect the head entry.
  - When empty: o_instr=NOP_INSTR, o_pc=0, o_imm_type=NO, o_illegal=0.
- o_ready: registered, equal to (next_count < 2). It never depends combinationally on i_ready.
- Simultaneous push and pop:
  - count=1: count stays 1; the new entry becomes head on the next cycle.
  - count=0: only a push is possible.
  - count=2: a push is impossible because o_ready=0.
- Pop and i_valid with o_ready=0: pop only; i_valid is ignored. Fetch must hold i_instr/i_pc until accepted.
- Flush:
  - Next state is count=0 and pointers=0.
  - A same-cycle push is dropped; flush has priority.
  - A same-cycle pop is irrelevant.
  - o_ready=1 and o_valid=0 on the following cycle.
- Reset mid-operation: identical to flush, plus all outputs return to their reset values. Reset has priority over flush.
- Classification uses the opcode i_instr[6:0]:
  - 0110011 -> RT=1
  - 0010011, 0000011, 1100111, 1110011, 0001111 -> IT=2
  - 0100011 -> ST=3
  - 1100011 -> BT=4
  - 0110111, 0010111 -> UT=5
  - 1101111 -> JT=6
  - any other opcode -> NO=0 with illegal=1
  - i_instr[1:0] != 2'b11 -> illegal=1 regardless of opcode.
- Illegal entries are still buffered and presented. Decode raises the exception.

Decomposition:
- Shared package: imm format codes (NO=0, RT=1, IT=2, ST=3, BT=4, UT=5, JT=6) and RV32I opcode constants.
  - The sign-extender and this block both use the format codes.
- Sub-module imm_type_decode: combinational, 32-bit instruction in, {imm_type[2:0], illegal} out. It is instantiated once on the push path.

Test Plan:
- Reset then idle: hold i_rst 2 cycles, release -> o_valid=0, o_ready=1, o_instr=32'h00000013, o_imm_type=0.
- Single push: i_instr=32'h00500093 (addi x1,x0,5), i_pc=0x100, i_ready=1 -> next cycle o_valid=1, o_imm_type=2, o_imm_data=0x0050000>>... (equal to instr[31:7]=25'h000A001), o_pc=0x100; the following cycle o_valid=0.
- Back-pressure: i_ready=0, push 0xFE000EE3 (BT) then 0x008000EF (JT) -> count=2, o_ready=0, head type 4; third i_valid ignored. Raise i_ready -> head type 6 next, then empty; order preserved.
- Simultaneous push/pop at count=1: stream 4 instructions with i_ready=1 every cycle -> o_valid continuously high after the first, one output per cycle, o_ready stays 1.
- Flush with push: count=2, assert i_flush and i_valid in the same cycle -> next cycle o_valid=0, o_ready=1; the pushed instruction never appears.
- Illegal opcodes: push 32'h0000007F -> o_imm_type=0, o_illegal=1. Push 32'h00000001 (bits[1:0]=01) -> o_illegal=1. Push 0x000000B7 (LUI) -> o_imm_type=5, o_illegal=0.
